// File: rtl/smc_cfreg_bank.sv
// SMC config register bank: per-CS shadow/active timing registers, pending status, ID.
// Latency: idle-CS writes are active the cycle after the access phase; busy-CS writes the cycle after busy drops.
// Backpressure: none; pready is tied high and every access completes in its access phase.
module smc_cfreg_bank #(
  parameter int          NUM_CS    = 4,
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] RESET_CFG = 32'hC000_0001,
  parameter logic [31:0] WMASK     = 32'h3FFF_FFFF,
  parameter logic [31:0] ID_VALUE  = 32'h0001_0000
) (
  input  logic                   hclk,
  input  logic                   sys_reset,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_W-1:0]      paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  input  logic [NUM_CS-1:0]      cs_busy,
  output logic [NUM_CS*32-1:0]   cfg_out,
  output logic [NUM_CS-1:0]      cfg_update
);

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_e;

  // Bits outside WMASK are pinned to their reset value on every write.
  localparam logic [31:0] FIXED_BITS = RESET_CFG & ~WMASK;

  logic              wr_access;
  logic              rd_access;
  logic [31:0]       wr_masked;
  logic [NUM_CS-1:0] write_hit;
  logic [NUM_CS-1:0] pending;
  logic [NUM_CS-1:0] commit;

  state_e      state_q  [NUM_CS];
  state_e      state_d  [NUM_CS];
  logic [31:0] shadow_q [NUM_CS];
  logic [31:0] shadow_d [NUM_CS];
  logic [31:0] active_q [NUM_CS];
  logic [31:0] active_d [NUM_CS];
  logic [NUM_CS-1:0] cfg_update_q;
  logic [NUM_CS-1:0] cfg_update_d;

  assign pready    = 1'b1;
  assign wr_access = psel & penable & pwrite;
  assign rd_access = psel & penable & ~pwrite;
  assign wr_masked = (pwdata & WMASK) | FIXED_BITS;

  // Decode access-phase writes onto the per-CS config registers.
  always_comb begin
    write_hit = '0;
    for (int n = 0; n < NUM_CS; n++) begin
      write_hit[n] = wr_access && (paddr == ADDR_W'(n));
    end
  end

  // Per-CS state register.
  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      for (int n = 0; n < NUM_CS; n++) state_q[n] <= S_IDLE;
    end else begin
      for (int n = 0; n < NUM_CS; n++) state_q[n] <= state_d[n];
    end
  end

  // Next state: a write to a busy CS parks it in PENDING; any non-busy cycle drains it to IDLE.
  always_comb begin
    for (int n = 0; n < NUM_CS; n++) begin
      state_d[n] = state_q[n];
      if (cs_busy[n]) begin
        if (write_hit[n]) state_d[n] = S_PENDING;
      end else begin
        state_d[n] = S_IDLE;
      end
    end
  end

  // FSM outputs: pending flag and the commit strobe (newest write data wins on a same-cycle write).
  always_comb begin
    pending = '0;
    commit  = '0;
    for (int n = 0; n < NUM_CS; n++) begin
      pending[n] = (state_q[n] == S_PENDING);
      commit[n]  = ~cs_busy[n] & (write_hit[n] | pending[n]);
    end
  end

  // Shadow always takes the latest write; active only moves on commit.
  always_comb begin
    for (int n = 0; n < NUM_CS; n++) begin
      shadow_d[n]     = write_hit[n] ? wr_masked : shadow_q[n];
      active_d[n]     = active_q[n];
      cfg_update_d[n] = commit[n];
      if (commit[n]) active_d[n] = shadow_d[n];
    end
  end

  // Config datapath and update-pulse registers.
  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      for (int n = 0; n < NUM_CS; n++) begin
        shadow_q[n] <= RESET_CFG;
        active_q[n] <= RESET_CFG;
      end
      cfg_update_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CS; n++) begin
        shadow_q[n] <= shadow_d[n];
        active_q[n] <= active_d[n];
      end
      cfg_update_q <= cfg_update_d;
    end
  end

  // Flatten active configs onto the output bus.
  always_comb begin
    cfg_out = '0;
    for (int n = 0; n < NUM_CS; n++) cfg_out[n*32 +: 32] = active_q[n];
  end

  assign cfg_update = cfg_update_q;

  // Read mux: config reads return shadow so software sees what it last wrote.
  always_comb begin
    prdata = '0;
    if (rd_access) begin
      for (int n = 0; n < NUM_CS; n++) begin
        if (paddr == ADDR_W'(n)) prdata = shadow_q[n];
      end
      if (paddr == ADDR_W'(NUM_CS))     prdata = 32'(pending);
      if (paddr == ADDR_W'(NUM_CS + 1)) prdata = ID_VALUE;
    end
  end

endmodule

// File: tb/tb_smc_cfreg_bank.sv
module tb_smc_cfreg_bank;

  localparam int          NUM_CS    = 4;
  localparam int          ADDR_W    = 4;
  localparam logic [31:0] RESET_CFG = 32'hC000_0001;
  localparam logic [31:0] WMASK     = 32'h3FFF_FFFF;
  localparam logic [31:0] ID_VALUE  = 32'h0001_0000;

  logic                  hclk = 1'b0;
  logic                  sys_reset;
  logic                  psel, penable, pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic [NUM_CS-1:0]     cs_busy;
  logic [NUM_CS*32-1:0]  cfg_out;
  logic [NUM_CS-1:0]     cfg_update;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: what software last wrote, what the memory side sees, and what is still owed.
  logic [31:0]       m_shadow [NUM_CS];
  logic [31:0]       m_active [NUM_CS];
  bit                m_owed   [NUM_CS];
  logic [NUM_CS-1:0] m_upd;

  smc_cfreg_bank #(
    .NUM_CS(NUM_CS), .ADDR_W(ADDR_W), .RESET_CFG(RESET_CFG),
    .WMASK(WMASK), .ID_VALUE(ID_VALUE)
  ) dut (
    .hclk(hclk), .sys_reset(sys_reset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .cs_busy(cs_busy), .cfg_out(cfg_out), .cfg_update(cfg_update)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_CS; n++) begin
      m_shadow[n] = RESET_CFG;
      m_active[n] = RESET_CFG;
      m_owed[n]   = 1'b0;
    end
    m_upd = '0;
  endtask

  function automatic logic [NUM_CS*32-1:0] exp_cfg();
    logic [NUM_CS*32-1:0] v;
    for (int n = 0; n < NUM_CS; n++) v[n*32 +: 32] = m_active[n];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic s, input logic e, input logic w, input int a);
    logic [31:0] st;
    st = '0;
    for (int n = 0; n < NUM_CS; n++) st[n] = m_owed[n];
    if (!(s && e && !w))  return 32'h0;
    if (a < NUM_CS)       return m_shadow[a];
    if (a == NUM_CS)      return st;
    if (a == NUM_CS + 1)  return ID_VALUE;
    return 32'h0;
  endfunction

  // A write lands in the shadow and becomes owed; anything owed is paid out on the first non-busy edge.
  task automatic model_step(input logic s, input logic e, input logic w, input int a,
                            input logic [31:0] d, input logic [NUM_CS-1:0] b);
    m_upd = '0;
    if (s && e && w && a < NUM_CS) begin
      m_shadow[a] = (d & WMASK) | (RESET_CFG & ~WMASK);
      m_owed[a]   = 1'b1;
    end
    for (int n = 0; n < NUM_CS; n++) begin
      if (!b[n] && m_owed[n]) begin
        m_active[n] = m_shadow[n];
        m_owed[n]   = 1'b0;
        m_upd[n]    = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic e, input logic w, input int a,
                       input logic [31:0] d, input logic [NUM_CS-1:0] b);
    @(negedge hclk);
    chk("cfg_out", cfg_out, exp_cfg());
    chk("cfg_update", cfg_update, m_upd);
    psel = s; penable = e; pwrite = w; paddr = ADDR_W'(a); pwdata = d; cs_busy = b;
    #1;
    chk("prdata", prdata, exp_rd(s, e, w, a));
    chk("pready", pready, 1'b1);
    @(posedge hclk);
    model_step(s, e, w, a, d, b);
  endtask

  task automatic apb_write(input int a, input logic [31:0] d, input logic [NUM_CS-1:0] b);
    cycle(1'b1, 1'b0, 1'b1, a, d, b);
    cycle(1'b1, 1'b1, 1'b1, a, d, b);
  endtask

  task automatic apb_read(input int a, input logic [NUM_CS-1:0] b);
    cycle(1'b1, 1'b0, 1'b0, a, 32'h0, b);
    cycle(1'b1, 1'b1, 1'b0, a, 32'h0, b);
  endtask

  task automatic idle(input logic [NUM_CS-1:0] b);
    cycle(1'b0, 1'b0, 1'b0, 0, 32'h0, b);
  endtask

  initial begin
    sys_reset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; cs_busy = '0;
    model_reset();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_cfg_out", cfg_out, exp_cfg());
    chk("rst_cfg_update", cfg_update, '0);
    sys_reset = 1'b0;

    // Reset readback of status and ID.
    apb_read(NUM_CS, 4'b0000);
    apb_read(NUM_CS + 1, 4'b0000);

    // Idle CS1 write commits the next cycle.
    apb_write(1, 32'h1234_5678, 4'b0000);
    idle(4'b0000);
    chk("cs1_value", cfg_out[63:32], 32'hD234_5678);
    apb_read(1, 4'b0000);

    // Busy CS2 write stays pending until busy drops.
    apb_write(2, 32'h0000_00AA, 4'b0100);
    apb_read(2, 4'b0100);
    apb_read(NUM_CS, 4'b0100);
    idle(4'b0100);
    idle(4'b0000);
    idle(4'b0000);
    chk("cs2_value", cfg_out[95:64], 32'hC000_00AA);
    apb_read(NUM_CS, 4'b0000);

    // Back-to-back busy writes to CS0; busy released together with the third.
    cycle(1'b1, 1'b1, 1'b1, 0, 32'h11, 4'b0001);
    cycle(1'b1, 1'b1, 1'b1, 0, 32'h22, 4'b0001);
    cycle(1'b1, 1'b1, 1'b1, 0, 32'h33, 4'b0000);
    idle(4'b0000);
    chk("cs0_value", cfg_out[31:0], 32'hC000_0033);
    idle(4'b0000);

    // Writes to status, ID and out-of-range indices are ignored; equal-value write still pulses.
    apb_write(NUM_CS, 32'hFFFF_FFFF, 4'b0000);
    apb_write(NUM_CS + 1, 32'hFFFF_FFFF, 4'b0000);
    apb_write(9, 32'hFFFF_FFFF, 4'b0000);
    apb_read(9, 4'b0000);
    apb_write(1, 32'h1234_5678, 4'b0000);
    idle(4'b0000);

    // Simultaneous commits on several CS.
    apb_write(0, 32'hA5A5_0000, 4'b1111);
    apb_write(3, 32'h0000_5A5A, 4'b1111);
    idle(4'b1111);
    idle(4'b0000);
    idle(4'b0000);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 9)), $urandom, 4'($urandom & $urandom));
    end
    idle(4'b0000);

    // Async reset while CS3 is pending.
    apb_write(3, 32'h0BAD_F00D, 4'b1000);
    apb_read(NUM_CS, 4'b1000);
    @(negedge hclk);
    chk("pre_rst_cfg_out", cfg_out, exp_cfg());
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #2 sys_reset = 1'b1;
    model_reset();
    #1;
    chk("arst_cfg_out", cfg_out, exp_cfg());
    chk("arst_cfg_update", cfg_update, '0);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = ADDR_W'(NUM_CS);
    #1;
    chk("arst_status", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0; cs_busy = '0;
    @(negedge hclk);
    sys_reset = 1'b0;
    repeat (4) idle(4'b0000);
    apb_read(NUM_CS, 4'b0000);
    apb_read(3, 4'b0000);
    idle(4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
